// File: rtl/uart_tx_rx_cfg.sv
// Full-duplex UART with configurable data bits, parity and stop bits.
// TX: valid/ready byte in, serial out. RX: 2-flop synchroniser, 3-sample majority
// vote per bit, false-start rejection, framing/parity/overrun reporting.
// Optional build macro UART_RX_FIFO_EN swaps the single RX holding register for a
// show-ahead FIFO of RX_FIFO_DEPTH entries.
module uart_tx_rx_cfg #(
  parameter int unsigned CLK_FREQUENCY = 48000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_vld,
  output logic                 tx_rdy,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_uart,
  input  logic                 rx_uart,
  output logic                 rx_vld,
  input  logic                 rx_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int unsigned CLKS_PER_BIT    = (CLK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
  localparam int unsigned CLKS_PER_BIT_WL = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BIT_CNT_WL      = $clog2(DATA_BITS + 1);
  localparam int unsigned MID             = CLKS_PER_BIT / 2;

  localparam logic [CLKS_PER_BIT_WL-1:0] CNT_LAST = CLKS_PER_BIT_WL'(CLKS_PER_BIT - 1);
  localparam logic [CLKS_PER_BIT_WL-1:0] SAMP0    = CLKS_PER_BIT_WL'(MID - 1);
  localparam logic [CLKS_PER_BIT_WL-1:0] SAMP1    = CLKS_PER_BIT_WL'(MID);
  localparam logic [CLKS_PER_BIT_WL-1:0] SAMP2    = CLKS_PER_BIT_WL'(MID + 1);
  localparam logic [BIT_CNT_WL-1:0]      BIT_LAST  = BIT_CNT_WL'(DATA_BITS - 1);
  localparam logic [BIT_CNT_WL-1:0]      STOP_LAST = BIT_CNT_WL'(STOP_BITS - 1);
  localparam logic PAR_EN  = (PARITY != 0);
  localparam logic PAR_ODD = (PARITY == 1);

  // Reject illegal configurations at elaboration
  if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || RX_FIFO_DEPTH < 2 ||
      (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx_rx_cfg: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // ---------------- TX ----------------
  state_e                     tx_state_q, tx_state_d;
  logic [CLKS_PER_BIT_WL-1:0] tx_cnt_q, tx_cnt_d;
  logic [BIT_CNT_WL-1:0]      tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]       tx_shift_q, tx_shift_d;
  logic                       tx_par_q, tx_par_d;
  logic                       tx_uart_q, tx_uart_d;
  logic                       tx_rdy_q, tx_rdy_d;

  // TX next state: each bit held CLKS_PER_BIT cycles, line value registered
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_uart_d  = tx_uart_q;
    tx_rdy_d   = tx_rdy_q;
    if (tx_state_q == S_IDLE) begin
      tx_uart_d = 1'b1;
      if (tx_vld && tx_rdy_q) begin
        tx_shift_d = tx_data;
        tx_par_d   = (^tx_data) ^ PAR_ODD;
        tx_state_d = S_START;
        tx_cnt_d   = '0;
        tx_uart_d  = 1'b0;
        tx_rdy_d   = 1'b0;
      end
    end else if (tx_cnt_q == CNT_LAST) begin
      tx_cnt_d = '0;
      case (tx_state_q)
        S_START: begin
          tx_state_d = S_DATA;
          tx_bit_d   = '0;
          tx_uart_d  = tx_shift_q[0];
        end
        S_DATA: begin
          if (tx_bit_q == BIT_LAST) begin
            tx_bit_d = '0;
            if (PAR_EN) begin
              tx_state_d = S_PARITY;
              tx_uart_d  = tx_par_q;
            end else begin
              tx_state_d = S_STOP;
              tx_uart_d  = 1'b1;
            end
          end else begin
            tx_bit_d   = tx_bit_q + BIT_CNT_WL'(1);
            tx_shift_d = tx_shift_q >> 1;
            tx_uart_d  = tx_shift_q[1];
          end
        end
        S_PARITY: begin
          tx_state_d = S_STOP;
          tx_bit_d   = '0;
          tx_uart_d  = 1'b1;
        end
        S_STOP: begin
          tx_uart_d = 1'b1;
          if (tx_bit_q == STOP_LAST) begin
            tx_state_d = S_IDLE;
            tx_rdy_d   = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + BIT_CNT_WL'(1);
          end
        end
        default: tx_state_d = S_IDLE;
      endcase
    end else begin
      tx_cnt_d = tx_cnt_q + CLKS_PER_BIT_WL'(1);
    end
  end

  // TX registers; reset drives the line idle immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_uart_q  <= 1'b1;
      tx_rdy_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_uart_q  <= tx_uart_d;
      tx_rdy_q   <= tx_rdy_d;
    end
  end

  assign tx_uart = tx_uart_q;
  assign tx_rdy  = tx_rdy_q;

  // ---------------- RX ----------------
  state_e                     rx_state_q, rx_state_d;
  logic [CLKS_PER_BIT_WL-1:0] rx_cnt_q, rx_cnt_d;
  logic [BIT_CNT_WL-1:0]      rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]       rx_shift_q, rx_shift_d;
  logic                       rx_s0_q, rx_s0_d, rx_s1_q, rx_s1_d;
  logic                       rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
  logic                       rx_done_q, rx_done_d;
  logic                       sync1_q, sync2_q;
  logic                       rx_maj;

  // Two-flop synchroniser, idles high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_uart;
      sync2_q <= sync1_q;
    end
  end

  assign rx_maj = (rx_s0_q & rx_s1_q) | (rx_s0_q & sync2_q) | (rx_s1_q & sync2_q);

  // RX next state: sample mid-1/mid/mid+1, decide at mid+1, leave STOP right after deciding
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_s0_d    = rx_s0_q;
    rx_s1_d    = rx_s1_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_done_d  = 1'b0;
    if (rx_state_q == S_IDLE) begin
      if (!sync2_q) begin
        rx_state_d = S_START;
        rx_cnt_d   = '0;
        rx_perr_d  = 1'b0;
      end
    end else begin
      rx_cnt_d = (rx_cnt_q == CNT_LAST) ? '0 : rx_cnt_q + CLKS_PER_BIT_WL'(1);
      if (rx_cnt_q == SAMP0) rx_s0_d = sync2_q;
      if (rx_cnt_q == SAMP1) rx_s1_d = sync2_q;
      case (rx_state_q)
        S_START: begin
          if (rx_cnt_q == SAMP2 && rx_maj) begin
            rx_state_d = S_IDLE;
          end else if (rx_cnt_q == CNT_LAST) begin
            rx_state_d = S_DATA;
            rx_bit_d   = '0;
          end
        end
        S_DATA: begin
          if (rx_cnt_q == SAMP2) rx_shift_d = {rx_maj, rx_shift_q[DATA_BITS-1:1]};
          if (rx_cnt_q == CNT_LAST) begin
            if (rx_bit_q == BIT_LAST) begin
              rx_state_d = PAR_EN ? S_PARITY : S_STOP;
              rx_bit_d   = '0;
            end else begin
              rx_bit_d = rx_bit_q + BIT_CNT_WL'(1);
            end
          end
        end
        S_PARITY: begin
          if (rx_cnt_q == SAMP2) rx_perr_d = ((^rx_shift_q) ^ rx_maj) != PAR_ODD;
          if (rx_cnt_q == CNT_LAST) rx_state_d = S_STOP;
        end
        S_STOP: begin
          if (rx_cnt_q == SAMP2) begin
            rx_ferr_d  = !rx_maj;
            rx_done_d  = 1'b1;
            rx_state_d = S_IDLE;
          end
        end
        default: rx_state_d = S_IDLE;
      endcase
    end
  end

  // RX registers; reset discards any partial frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_s0_q    <= 1'b1;
      rx_s1_q    <= 1'b1;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s0_q    <= rx_s0_d;
      rx_s1_q    <= rx_s1_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_done_q  <= rx_done_d;
    end
  end

  // ---------------- RX output stage ----------------
  logic ovr_q, ovr_d;

`ifdef UART_RX_FIFO_EN
  localparam int unsigned FIFO_AW = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned ENTRY_W = DATA_BITS + 2;

  logic [ENTRY_W-1:0] mem_q [RX_FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [RX_FIFO_DEPTH];
  logic [FIFO_AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic               fifo_empty, fifo_full, fifo_pop, fifo_push;

  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[FIFO_AW] != rd_q[FIFO_AW]) &&
                      (wr_q[FIFO_AW-1:0] == rd_q[FIFO_AW-1:0]);
  assign fifo_pop   = !fifo_empty && rx_rdy;
  assign fifo_push  = rx_done_q && (!fifo_full || fifo_pop);

  // FIFO next state: a pop frees the slot a simultaneous push writes
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q + (FIFO_AW + 1)'(fifo_push);
    rd_d  = rd_q + (FIFO_AW + 1)'(fifo_pop);
    ovr_d = rx_done_q && fifo_full && !fifo_pop;
    if (fifo_push) mem_d[wr_q[FIFO_AW-1:0]] = {rx_perr_q, rx_ferr_q, rx_shift_q};
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(RX_FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      ovr_q <= ovr_d;
    end
  end

  assign rx_vld = !fifo_empty;
  assign {rx_parity_err, rx_frame_err, rx_data} = mem_q[rd_q[FIFO_AW-1:0]];
`else
  logic                 out_vld_q, out_vld_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic                 out_ferr_q, out_ferr_d, out_perr_q, out_perr_d;

  // Holding register: load when empty or being consumed, otherwise drop and flag overrun
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_ferr_d = out_ferr_q;
    out_perr_d = out_perr_q;
    ovr_d      = 1'b0;
    if (out_vld_q && rx_rdy) out_vld_d = 1'b0;
    if (rx_done_q) begin
      if (!out_vld_q || rx_rdy) begin
        out_vld_d  = 1'b1;
        out_data_d = rx_shift_q;
        out_ferr_d = rx_ferr_q;
        out_perr_d = rx_perr_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Holding register flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_ferr_q <= 1'b0;
      out_perr_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_ferr_q <= out_ferr_d;
      out_perr_q <= out_perr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_vld        = out_vld_q;
  assign rx_data       = out_data_q;
  assign rx_frame_err  = out_ferr_q;
  assign rx_parity_err = out_perr_q;
`endif

  assign rx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_tx_rx_cfg.sv
// Directed/randomised bench for uart_tx_rx_cfg at 16 clocks per bit.
// Instance a: 8N1, RX driven by the bench. Instance b: 8 data, even parity, 2 stop,
// RX either driven by the bench or looped back from its own TX.
module tb_uart_tx_rx_cfg;

  localparam int unsigned CLK_HZ = 1843200;
  localparam int unsigned BAUD   = 115200;
  localparam int          CPB    = 16;
`ifdef UART_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       a_tx_vld, a_tx_rdy, a_tx_uart, a_rx_uart, a_rx_vld, a_rx_rdy;
  logic [7:0] a_tx_data, a_rx_data;
  logic       a_ferr, a_perr, a_ovr;
  logic       b_tx_vld, b_tx_rdy, b_tx_uart, b_rx_uart, b_rx_vld, b_rx_rdy;
  logic [7:0] b_tx_data, b_rx_data;
  logic       b_ferr, b_perr, b_ovr;
  logic       b_loop, b_rx_drv, b_mon;

  assign b_rx_uart = b_loop ? b_tx_uart : b_rx_drv;

  uart_tx_rx_cfg #(.CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .RX_FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset_n(reset_n), .tx_vld(a_tx_vld), .tx_rdy(a_tx_rdy), .tx_data(a_tx_data),
    .tx_uart(a_tx_uart), .rx_uart(a_rx_uart), .rx_vld(a_rx_vld), .rx_rdy(a_rx_rdy),
    .rx_data(a_rx_data), .rx_frame_err(a_ferr), .rx_parity_err(a_perr), .rx_overrun(a_ovr));

  uart_tx_rx_cfg #(.CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(2), .RX_FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset_n(reset_n), .tx_vld(b_tx_vld), .tx_rdy(b_tx_rdy), .tx_data(b_tx_data),
    .tx_uart(b_tx_uart), .rx_uart(b_rx_uart), .rx_vld(b_rx_vld), .rx_rdy(b_rx_rdy),
    .rx_data(b_rx_data), .rx_frame_err(b_ferr), .rx_parity_err(b_perr), .rx_overrun(b_ovr));

  int checks   = 0;
  int failures = 0;

  // Overrun pulses of instance a (one count per cycle high)
  int a_ovr_cnt = 0;
  always @(posedge clk) if (a_ovr) a_ovr_cnt <= a_ovr_cnt + 1;

  // Loopback scoreboard for instance b: words must come back in send order, error-free
  logic [7:0] b_sent[$];
  int b_got = 0;
  int b_bad = 0;
  always @(posedge clk) begin
    if (b_mon && b_rx_vld && b_rx_rdy) begin
      if (b_sent.size() == 0 || b_rx_data !== b_sent[0] || b_ferr !== 1'b0 || b_perr !== 1'b0)
        b_bad <= b_bad + 1;
      if (b_sent.size() != 0) void'(b_sent.pop_front());
      b_got <= b_got + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Line levels of one frame, index 0 = start bit
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input int par, input int stops);
    logic [15:0] b;
    int k;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1+i] = d[i];
    k = 9;
    if (par != 0) begin
      b[k] = (par == 1) ? ~(^d) : (^d);
      k++;
    end
    for (int i = 0; i < stops; i++) b[k+i] = 1'b1;
    return b;
  endfunction

  // Send one word on a's TX and compare every line cycle with the expected frame
  task automatic a_tx_check(input logic [7:0] d, input string tag);
    logic [15:0] bits;
    int bad, rdy_bad;
    bits = frame_bits(d, 0, 1);
    bad = 0;
    rdy_bad = 0;
    check({tag, "_rdy_pre"}, 32'(a_tx_rdy), 32'd1);
    a_tx_vld  = 1'b1;
    a_tx_data = d;
    tick();
    a_tx_vld = 1'b0;
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c > 0) tick();
      if (a_tx_uart !== bits[c/CPB]) bad++;
      if (a_tx_rdy !== 1'b0) rdy_bad++;
    end
    check({tag, "_wave_bad_cycles"}, 32'(bad), 32'd0);
    check({tag, "_rdy_low_bad"}, 32'(rdy_bad), 32'd0);
    tick();
    check({tag, "_rdy_back_160"}, 32'(a_tx_rdy), 32'd1);
    check({tag, "_idle_line"}, 32'(a_tx_uart), 32'd1);
  endtask

  // Drive n bit periods onto a's or b's RX line, optionally inverting one cycle
  task automatic drive_rx(input bit sel_b, input logic [15:0] bits, input int n, input int glitch_c);
    logic v;
    for (int c = 0; c < n * CPB; c++) begin
      v = bits[c/CPB];
      if (c == glitch_c) v = ~v;
      if (sel_b) b_rx_drv = v; else a_rx_uart = v;
      tick();
    end
    if (sel_b) b_rx_drv = 1'b1; else a_rx_uart = 1'b1;
    repeat (20) tick();
  endtask

  task automatic a_rx_expect(input string tag, input logic [7:0] d, input logic fe, input logic pe);
    check({tag, "_vld"}, 32'(a_rx_vld), 32'd1);
    check({tag, "_data"}, 32'(a_rx_data), 32'(d));
    check({tag, "_ferr"}, 32'(a_ferr), 32'(fe));
    check({tag, "_perr"}, 32'(a_perr), 32'(pe));
    a_rx_rdy = 1'b1;
    tick();
    a_rx_rdy = 1'b0;
    check({tag, "_vld_after_pop"}, 32'(a_rx_vld), 32'd0);
  endtask

  initial begin
    logic [7:0]  d;
    logic [15:0] bits;
    logic [7:0]  expq[$];
    int ovr0, cnt, lenbad, k;

    reset_n = 1'b0;
    a_tx_vld = 1'b0; a_tx_data = '0; a_rx_uart = 1'b1; a_rx_rdy = 1'b0;
    b_tx_vld = 1'b0; b_tx_data = '0; b_rx_drv = 1'b1; b_rx_rdy = 1'b0;
    b_loop = 1'b0; b_mon = 1'b0;
    repeat (3) tick();
    check("rst_tx_uart", 32'(a_tx_uart), 32'd1);
    check("rst_tx_rdy", 32'(a_tx_rdy), 32'd1);
    check("rst_rx_vld", 32'(a_rx_vld), 32'd0);
    check("rst_rx_data", 32'(a_rx_data), 32'd0);
    check("rst_errs", 32'({a_ferr, a_perr, a_ovr}), 32'd0);
    check("rst_b_tx_uart", 32'(b_tx_uart), 32'd1);
    reset_n = 1'b1;
    repeat (2) tick();

    // TX waveform: fixed 0xA5 then random words
    a_tx_check(8'hA5, "tx_a5");
    repeat (2) a_tx_check(8'($urandom), "tx_rand");

    // RX clean frames
    repeat (2) begin
      d = 8'($urandom);
      drive_rx(1'b0, frame_bits(d, 0, 1), 10, -1);
      a_rx_expect("rx_clean", d, 1'b0, 1'b0);
    end

    // False start: short low pulse produces nothing, next frame still decodes
    a_rx_uart = 1'b0;
    repeat (3) tick();
    a_rx_uart = 1'b1;
    repeat (40) tick();
    check("false_start_no_vld", 32'(a_rx_vld), 32'd0);
    d = 8'($urandom);
    k = int'($urandom_range(0, 7));
    drive_rx(1'b0, frame_bits(d, 0, 1), 10, CPB * (1 + k) + CPB / 2);
    a_rx_expect("rx_glitch", d, 1'b0, 1'b0);

    // Stop bit driven low: framing error, data intact
    bits = frame_bits(8'h3C, 0, 1);
    bits[9] = 1'b0;
    drive_rx(1'b0, bits, 10, -1);
    a_rx_expect("rx_frame_err", 8'h3C, 1'b1, 1'b0);

    // Even-parity instance: inverted parity bit, then a clean frame
    d = 8'($urandom);
    bits = frame_bits(d, 2, 2);
    bits[9] = ~bits[9];
    drive_rx(1'b1, bits, 12, -1);
    check("b_perr_vld", 32'(b_rx_vld), 32'd1);
    check("b_perr_data", 32'(b_rx_data), 32'(d));
    check("b_perr_flag", 32'(b_perr), 32'd1);
    check("b_perr_ferr", 32'(b_ferr), 32'd0);
    b_rx_rdy = 1'b1;
    tick();
    b_rx_rdy = 1'b0;
    d = 8'($urandom);
    drive_rx(1'b1, frame_bits(d, 2, 2), 12, -1);
    check("b_ok_data", 32'(b_rx_data), 32'(d));
    check("b_ok_errs", 32'({b_ferr, b_perr}), 32'd0);
    b_rx_rdy = 1'b1;
    tick();
    check("b_ok_popped", 32'(b_rx_vld), 32'd0);

    // Overrun: consumer stalled, CAP frames held in order, the next one dropped
    ovr0 = a_ovr_cnt;
    for (int i = 0; i <= CAP; i++) begin
      d = (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : 8'($urandom);
      if (expq.size() < CAP) expq.push_back(d);
      drive_rx(1'b0, frame_bits(d, 0, 1), 10, -1);
      check("ovr_pulses", 32'(a_ovr_cnt - ovr0), 32'((i >= CAP) ? 1 : 0));
    end
    while (expq.size() != 0) begin
      d = expq.pop_front();
      check("ovr_held_vld", 32'(a_rx_vld), 32'd1);
      check("ovr_held_data", 32'(a_rx_data), 32'(d));
      a_rx_rdy = 1'b1;
      tick();
      a_rx_rdy = 1'b0;
    end
    check("ovr_drained", 32'(a_rx_vld), 32'd0);

    // Loopback on b: 0x00..0xFF back-to-back with tx_vld held high
    b_loop = 1'b1;
    b_mon  = 1'b1;
    lenbad = 0;
    for (int i = 0; i < 256; i++) begin
      b_tx_vld  = 1'b1;
      b_tx_data = 8'(i);
      b_sent.push_back(8'(i));
      tick();
      cnt = 1;
      while (!b_tx_rdy && cnt < 400) begin
        tick();
        cnt++;
      end
      if (cnt != 193) lenbad++;
    end
    b_tx_vld = 1'b0;
    cnt = 0;
    while (b_got < 256 && cnt < 1000) begin
      tick();
      cnt++;
    end
    check("loop_frame_len_bad", 32'(lenbad), 32'd0);
    check("loop_words_got", 32'(b_got), 32'd256);
    check("loop_words_bad", 32'(b_bad), 32'd0);
    b_mon = 1'b0;
    b_loop = 1'b0;

    // Reset in the middle of a TX and an RX frame
    d = 8'($urandom);
    bits = frame_bits(8'($urandom), 0, 1);
    a_tx_vld  = 1'b1;
    a_tx_data = d;
    for (int c = 0; c < 4 * CPB + CPB / 2; c++) begin
      a_rx_uart = bits[c/CPB];
      tick();
      a_tx_vld = 1'b0;
    end
    check("mid_tx_busy", 32'(a_tx_rdy), 32'd0);
    reset_n = 1'b0;
    #1;
    check("rst_mid_tx_uart", 32'(a_tx_uart), 32'd1);
    check("rst_mid_tx_rdy", 32'(a_tx_rdy), 32'd1);
    check("rst_mid_rx_vld", 32'(a_rx_vld), 32'd0);
    a_rx_uart = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (30) tick();
    check("rst_mid_no_rx", 32'(a_rx_vld), 32'd0);
    a_tx_check(8'($urandom), "tx_after_rst");
    d = 8'($urandom);
    drive_rx(1'b0, frame_bits(d, 0, 1), 10, -1);
    a_rx_expect("rx_after_rst", d, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
